// File: rtl/demux_capture_8ch_if.sv
// Bundle of the capture stage's data, control and status signals.
// The master side drives y/clear/rd_sel; the slave (the capture block) drives status.
interface demux_capture_8ch_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       y;
    logic             clear;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic [7:0]       hit;
    logic [2:0]       last_ch;
    logic             last_vld;
    logic             multi_err;
    logic [7:0]       sat;

    modport master (
        output y, clear, rd_sel,
        input  rd_data, hit, last_ch, last_vld, multi_err, sat
    );

    modport slave (
        input  y, clear, rd_sel,
        output rd_data, hit, last_ch, last_vld, multi_err, sat
    );
endinterface

// File: rtl/demux_capture_8ch.sv
// Eight-channel capture of demux outputs: per-channel rising-edge counters,
// sticky hit flags, last-hit index and a sticky multi-hot error flag.
module demux_capture_8ch #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    demux_capture_8ch_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]       y_q_reg;
    logic [7:0]       y_qq_reg;
    logic [7:0]       rise;
    logic             any_rise;
    logic             multi_hot;

    logic [CNT_W-1:0] cnt_reg  [8];
    logic [CNT_W-1:0] cnt_next [8];
    logic [7:0]       hit_reg;
    logic [2:0]       last_ch_reg;
    logic [2:0]       last_ch_next;
    logic             last_vld_reg;
    logic             multi_err_reg;

    // Input history is only cleared by rst, so a level held through clear is not recounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg  <= '0;
            y_qq_reg <= '0;
        end else begin
            y_q_reg  <= bus.y;
            y_qq_reg <= y_q_reg;
        end
    end

    assign rise      = y_q_reg & ~y_qq_reg;
    assign any_rise  = |rise;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hot = |(y_q_reg & (y_q_reg - 8'd1));

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            assign cnt_next[gi] = (rise[gi] && (cnt_reg[gi] != CNT_MAX))
                                  ? cnt_reg[gi] + CNT_W'(1)
                                  : cnt_reg[gi];
            assign bus.sat[gi]  = (cnt_reg[gi] == CNT_MAX);
        end
    endgenerate

    // Later (higher) channels overwrite earlier ones, so the highest rising index wins.
    always_comb begin
        last_ch_next = last_ch_reg;
        for (int k = 0; k < 8; k++) begin
            if (rise[k]) begin
                last_ch_next = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int k = 0; k < 8; k++) begin
                cnt_reg[k] <= '0;
            end
            hit_reg       <= '0;
            last_ch_reg   <= '0;
            last_vld_reg  <= 1'b0;
            multi_err_reg <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                cnt_reg[k] <= cnt_next[k];
            end
            hit_reg     <= hit_reg | rise;
            last_ch_reg <= last_ch_next;
            if (any_rise) begin
                last_vld_reg <= 1'b1;
            end
            if (multi_hot) begin
                multi_err_reg <= 1'b1;
            end
        end
    end

    assign bus.rd_data   = cnt_reg[bus.rd_sel];
    assign bus.hit       = hit_reg;
    assign bus.last_ch   = last_ch_reg;
    assign bus.last_vld  = last_vld_reg;
    assign bus.multi_err = multi_err_reg;
endmodule

// File: tb/tb_demux_capture_8ch.sv
// Scoreboard bench for demux_capture_8ch: each driven y pushes its pending
// edge/multi-hot event; the event is popped and applied one edge later.
module tb_demux_capture_8ch;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] rise;
        logic       multi;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_capture_8ch_if #(.CNT_W(CNT_W)) intf ();

    demux_capture_8ch #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    pend_t      sb_q [$];
    logic [7:0] prev_y;
    int         m_cnt [8];
    logic [7:0] m_hit;
    logic [2:0] m_last_ch;
    logic       m_last_vld;
    logic       m_merr;
    int         rd_rot = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_hit      = '0;
        m_last_ch  = '0;
        m_last_vld = 1'b0;
        m_merr     = 1'b0;
    endtask

    // One capture cycle: drive, push pending event, clock, pop and compare.
    task automatic step(input logic [7:0] yv, input logic clr);
        pend_t      e;
        logic [7:0] exp_sat;
        int         sel;
        sel          = rd_rot % 8;
        intf.y       = yv;
        intf.clear   = clr;
        intf.rd_sel  = 3'(sel);
        e.rise       = yv & ~prev_y;
        e.multi      = ($countones(yv) >= 2);
        prev_y       = yv;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (clr) begin
            model_zero();
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (e.rise[k]) begin
                    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
                    m_hit[k]   = 1'b1;
                    m_last_ch  = 3'(k);
                    m_last_vld = 1'b1;
                end
            end
            if (e.multi) m_merr = 1'b1;
        end
        exp_sat = '0;
        for (int k = 0; k < 8; k++) exp_sat[k] = (m_cnt[k] == CNT_MAX);
        check("hit",       32'(intf.hit),       32'(m_hit));
        check("last_ch",   32'(intf.last_ch),   32'(m_last_ch));
        check("last_vld",  32'(intf.last_vld),  32'(m_last_vld));
        check("multi_err", 32'(intf.multi_err), 32'(m_merr));
        check("sat",       32'(intf.sat),       32'(exp_sat));
        check($sformatf("rd_data_sel%0d", sel), 32'(intf.rd_data), 32'(m_cnt[sel]));
        rd_rot++;
    endtask

    // Combinational read-port probe between edges against a fixed expectation.
    task automatic peek_cnt(input int k, input int exp);
        intf.rd_sel = 3'(k);
        #1;
        check($sformatf("peek_rd_data%0d", k), 32'(intf.rd_data), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        intf.y      = '0;
        intf.clear  = 1'b0;
        intf.rd_sel = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit",       32'(intf.hit),       32'h0);
        check("rst_last_ch",   32'(intf.last_ch),   32'h0);
        check("rst_last_vld",  32'(intf.last_vld),  32'h0);
        check("rst_multi_err", 32'(intf.multi_err), 32'h0);
        check("rst_sat",       32'(intf.sat),       32'h0);
        for (int k = 0; k < 8; k++) peek_cnt(k, 0);
        rst    = 1'b0;
        prev_y = '0;
        model_zero();
        sb_q.delete();
        sb_q.push_back('0);
        $display("[tb] reset done");

        for (int k = 0; k < 8; k++) begin
            step(8'(1 << k), 1'b0);
            step(8'h00, 1'b0);
        end
        step(8'h00, 1'b0);
        check("sweep_hit",      32'(intf.hit),       32'hFF);
        check("sweep_last_ch",  32'(intf.last_ch),   32'd7);
        check("sweep_last_vld", 32'(intf.last_vld),  32'd1);
        check("sweep_merr",     32'(intf.multi_err), 32'd0);
        for (int k = 0; k < 8; k++) peek_cnt(k, 1);
        $display("[tb] one-hot sweep done");

        step(8'h00, 1'b1);
        repeat (10) step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        peek_cnt(2, 1);
        repeat (5) begin
            step(8'h04, 1'b0);
            step(8'h00, 1'b0);
        end
        step(8'h00, 1'b0);
        peek_cnt(2, 6);
        $display("[tb] level vs pulse done");

        repeat (260) begin
            step(8'h01, 1'b0);
            step(8'h00, 1'b0);
        end
        step(8'h00, 1'b0);
        peek_cnt(0, 255);
        check("sat_flag", 32'(intf.sat), 32'h01);
        repeat (3) begin
            step(8'h01, 1'b0);
            step(8'h00, 1'b0);
        end
        step(8'h00, 1'b0);
        peek_cnt(0, 255);
        $display("[tb] saturation done");

        step(8'h00, 1'b1);
        step(8'h41, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        check("mh_merr",    32'(intf.multi_err), 32'd1);
        check("mh_last_ch", 32'(intf.last_ch),   32'd6);
        peek_cnt(0, 1);
        peek_cnt(6, 1);
        $display("[tb] multi-hot done");

        step(8'h10, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        check("clr_hit",      32'(intf.hit),       32'h0);
        check("clr_last_vld", 32'(intf.last_vld),  32'h0);
        check("clr_merr",     32'(intf.multi_err), 32'h0);
        peek_cnt(4, 0);
        step(8'h10, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        peek_cnt(4, 1);
        $display("[tb] clear collision done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_capture_8ch.md
# demux_capture_8ch

Eight-channel capture stage that sits directly downstream of the 1-to-8 demultiplexer and consumes its eight outputs y1..y8. It registers the outputs, detects rising edges per channel, and keeps a saturating edge counter, a sticky hit flag and a last-hit channel index for each. It also flags protocol errors when more than one demux output is high in the same cycle. A combinational read port exposes any channel's counter.

## Interface
Parameters:
- CNT_W, default 8: width of each per-channel edge counter; legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- y  input  8  demux outputs; y[0] = y1 ... y[7] = y8; asynchronous to nothing, assumed clk-synchronous.
- clear  input  1  synchronous clear of counters, sticky flags, last-hit and error state; does not clear input pipeline.
- rd_sel  input  3  channel index for the read port; 0 selects y1.
- rd_data  output  CNT_W  counter of channel rd_sel; combinational from counter array.
- hit  output  8  sticky per-channel flag, set on first rising edge.
- last_ch  output  3  index of most recently detected rising edge.
- last_vld  output  1  high once any rising edge has been detected since reset/clear.
- multi_err  output  1  sticky; set when two or more bits of the registered y are high in one cycle.
- sat  output  8  per-channel flag, high while that counter equals 2^CNT_W-1.

## Operation
- Input stage: y_q <= y; y_qq <= y_q each clock. rise[k] = y_q[k] & ~y_qq[k].
- Per channel k: if rise[k] and cnt[k] != all-ones, cnt[k] <= cnt[k]+1; at all-ones it holds (saturates, no wrap). hit[k] <= 1 on rise[k].
- last_ch: on any rise, loaded with the index of the highest-numbered rising channel that cycle; last_vld <= 1. No rise: holds.
- multi_err: set when popcount(y_q) >= 2; stays set until clear or rst. Counting continues normally for every rising channel in a multi-hot cycle.
- clear priority: when clear is high, cnt, hit, last_ch, last_vld, multi_err are zeroed that edge; any rise in the same cycle is dropped (not counted, not flagged). y_q/y_qq keep updating, so a level held through clear is not recounted.
- rst priority over clear. rst zeros everything including y_q and y_qq.
- rd_data = cnt[rd_sel]; sat[k] = (cnt[k] == 2^CNT_W-1). Both purely combinational from registers.
- No state machine beyond the counters; no handshake — every clock is a capture cycle.

## Timing
- Reset values: rd_data 0 (all counters 0), hit 8'h00, last_ch 0, last_vld 0, multi_err 0, sat 8'h00; y_q, y_qq 0.
- Because y_qq resets to 0, a channel already high at the first post-reset sample counts as one rising edge.
- Latency: y[k] rising before edge N is captured in y_q at N; cnt/hit/last_ch/last_vld update at edge N+1; visible on outputs after edge N+1 (2 clocks input-to-output).
- multi_err: multi-hot y before edge N -> multi_err high after edge N+1.
- A channel held high for many cycles counts once; a 1-cycle pulse counts once; back-to-back pulses separated by one low cycle count twice.
- rd_sel change reflects on rd_data in the same cycle (no register).
- Reset or clear mid-activity: takes effect on that edge; the next edge resumes counting from 0 using the current y_q/y_qq history.

## Test plan
- Reset: hold rst 2 cycles with y=8'h00 -> all outputs zero; rd_data 0 for every rd_sel 0..7.
- Single-channel sweep: drive select-style one-hot y = 1<<k for one cycle, then 8'h00, for k=0..7 -> each cnt=1, hit=8'hFF, last_ch=7, last_vld=1, multi_err=0; each update appears exactly 2 clocks after y.
- Level vs pulse: y=8'h04 held 10 cycles -> cnt[2]=1; then 5 pulses of 1 high/1 low -> cnt[2]=6.
- Saturation (CNT_W=8): 260 pulses on y1 -> rd_data(rd_sel=0)=255, sat=8'h01; further pulses leave 255.
- Multi-hot: y=8'h41 one cycle -> multi_err=1, cnt[0]=cnt[6]=1, last_ch=6; multi_err stays 1 after y returns to 0.
- Clear collision: pulse y=8'h10 so its rise coincides with clear=1 -> cnt[4]=0, hit=0, last_vld=0, multi_err=0; following pulse counts to 1.
